// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 8-bit CPU control path: opcode values, sequencer
// state encoding, ALU/register-source encodings shared with the datapath, and
// the bundle of control strobes produced by cpu_decode.
package cpu_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_ADDI  = 8'h02;
  localparam logic [7:0] OP_LOAD  = 8'h03;
  localparam logic [7:0] OP_STORE = 8'h04;
  localparam logic [7:0] OP_JMPZ  = 8'h05;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] REG_SRC_ALU = 2'b00;
  localparam logic [1:0] REG_SRC_MEM = 2'b01;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       reg_write;
    logic [1:0] reg_src;
    logic [1:0] alu_op;
    logic       alu_src;
  } strobes_t;

  function automatic logic is_known_op(input logic [7:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_ADDI, OP_LOAD, OP_STORE, OP_JMPZ, OP_HALT: is_known_op = 1'b1;
      default:                                                     is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode
// Combinational map from sequencer state to datapath control strobes.
// Ports:
//   en         - strobes are forced to 0 when low (held low during reset)
//   state      - current sequencer state
//   op_q       - opcode latched in DECODE, used by EXEC/MEM/WB
//   opcode     - live IR contents, only consulted while in DECODE
//   run        - fetch enable
//   zero_flag  - ALU zero flag, sampled by JMPZ in EXEC
//   mem_ready  - RAM handshake, only meaningful while a request is issued
//   strb       - bundled control strobes
module cpu_decode
  import cpu_pkg::*;
(
  input  logic       en,
  input  state_t     state,
  input  logic [7:0] op_q,
  input  logic [7:0] opcode,
  input  logic       run,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output strobes_t   strb
);

  always_comb begin
    strb = '0;
    if (en) begin
      unique case (state)
        ST_FETCH: begin
          if (run) begin
            strb.mem_req = 1'b1;
            strb.ir_load = mem_ready;
          end
        end
        ST_DECODE: begin
          // NOP and unknown opcodes finish here, so they advance the PC now.
          if (opcode == OP_NOP || !is_known_op(opcode)) strb.pc_inc = 1'b1;
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADD, OP_ADDI: begin
              strb.reg_write = 1'b1;
              strb.reg_src   = REG_SRC_ALU;
              strb.alu_op    = ALU_ADD;
              strb.alu_src   = (op_q == OP_ADDI);
              strb.pc_inc    = 1'b1;
            end
            OP_JMPZ: begin
              strb.pc_load = zero_flag;
              strb.pc_inc  = !zero_flag;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          strb.mem_req      = 1'b1;
          strb.mem_addr_src = 1'b1;
          strb.mem_we       = (op_q == OP_STORE);
          strb.pc_inc       = mem_ready && (op_q == OP_STORE);
        end
        ST_WB: begin
          strb.reg_write = 1'b1;
          strb.reg_src   = REG_SRC_MEM;
          strb.pc_inc    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle fetch/decode/execute sequencer. One shared RAM serves both
// instruction fetch and LOAD/STORE; wait states come through mem_ready.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   run                    - when low no new fetch is issued
//   opcode, zero_flag      - IR contents and ALU zero flag
//   mem_ready              - RAM access complete (qualified by mem_req)
//   mem_req/mem_we/mem_addr_src, ir_load, pc_inc, pc_load,
//   reg_write, reg_src, alu_op, alu_src - datapath strobes
//   state, halted, illegal, retired    - status / debug
//
// state  | meaning
// FETCH  | request instruction at PC, wait for mem_ready, load IR
// DECODE | latch opcode, dispatch; NOP/unknown finish here
// EXEC   | ALU ops write back, JMPZ updates PC
// MEM    | data access at ALU address, wait for mem_ready
// WB     | LOAD writes RAM data to register file
// HALT   | stopped until reset
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [7:0]       opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_src,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             reg_write,
  output logic [1:0]       reg_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  strobes_t         strb;

  cpu_decode u_decode (
    .en        (rst_n),
    .state     (state_q),
    .op_q      (op_q),
    .opcode    (opcode),
    .run       (run),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .strb      (strb)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      ST_FETCH: begin
        if (run && mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_ADD, OP_ADDI, OP_JMPZ: state_d = ST_EXEC;
          OP_LOAD, OP_STORE:        state_d = ST_MEM;
          OP_HALT:                  state_d = ST_HALT;
          default:                  state_d = ST_FETCH;
        endcase
      end
      ST_EXEC: state_d = ST_FETCH;
      ST_MEM: begin
        if (mem_ready) state_d = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // An instruction retires when it hands control back to FETCH or enters HALT.
  assign retire = (state_q != ST_FETCH && state_d == ST_FETCH) ||
                  (state_q != ST_HALT  && state_d == ST_HALT);

  always_comb begin
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    illegal_d = illegal_q | (state_q == ST_DECODE && !is_known_op(opcode));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign mem_req      = strb.mem_req;
  assign mem_we       = strb.mem_we;
  assign mem_addr_src = strb.mem_addr_src;
  assign ir_load      = strb.ir_load;
  assign pc_inc       = strb.pc_inc;
  assign pc_load      = strb.pc_load;
  assign reg_write    = strb.reg_write;
  assign reg_src      = strb.reg_src;
  assign alu_op       = strb.alu_op;
  assign alu_src      = strb.alu_src;
  assign state        = state_q;
  assign halted       = (state_q == ST_HALT);
  assign illegal      = illegal_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  opcode;
  logic        zero_flag;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_src, ir_load, pc_inc, pc_load, reg_write;
  logic [1:0]  reg_src, alu_op;
  logic        alu_src;
  logic [2:0]  state;
  logic        halted, illegal;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [15:0] exp_ret;
  logic        exp_ill;

  // per-instruction observations
  int   n_rw, n_inc, n_ld, n_both, n_we, n_dreq, n_freq, n_ir, n_aluop;
  logic last_alu_src;
  logic [1:0] last_reg_src;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_src(mem_addr_src), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .reg_write(reg_write), .reg_src(reg_src),
    .alu_op(alu_op), .alu_src(alu_src), .state(state), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit known(input logic [7:0] op);
    return (op <= 8'h05) || (op == 8'hFF);
  endfunction

  // Minimum cycles with no wait states, taken from the instruction timing table.
  function automatic int base_cycles(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h05, 8'h04: return 3;
      8'h03:                      return 4;
      default:                    return 2;
    endcase
  endfunction

  // Runs one instruction from FETCH until it returns to FETCH or enters HALT.
  // fw/mw: cycles mem_ready is held low in the fetch / data access.
  task automatic run_instr(input logic [7:0] op, input int fw, input int mw,
                           input logic zf, input bit drop_run, output int cyc);
    int  fcnt, mcnt;
    bit  left, done, dropped;
    bit  is_mem;
    int  exp_cyc;
    fcnt = 0; mcnt = 0; left = 0; done = 0; dropped = 0; cyc = 0;
    n_rw = 0; n_inc = 0; n_ld = 0; n_both = 0; n_we = 0; n_dreq = 0;
    n_freq = 0; n_ir = 0; n_aluop = 0; last_alu_src = 1'bx; last_reg_src = 2'bxx;
    while (!done && cyc < 40) begin
      @(negedge clk);
      opcode = op; zero_flag = zf;
      if (drop_run && state == 3'd3) dropped = 1;
      run = !dropped;
      #1;
      if (mem_req) begin
        if (!mem_addr_src) begin mem_ready = (fcnt >= fw); fcnt++; end
        else               begin mem_ready = (mcnt >= mw); mcnt++; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      cyc++;
      if (reg_write) begin n_rw++; last_alu_src = alu_src; last_reg_src = reg_src; end
      if (pc_inc) n_inc++;
      if (pc_load) n_ld++;
      if (pc_inc && pc_load) n_both++;
      if (mem_req && mem_we) n_we++;
      if (mem_req && mem_addr_src) n_dreq++;
      if (mem_req && !mem_addr_src) n_freq++;
      if (ir_load) n_ir++;
      if (alu_op != 2'b00) n_aluop++;
      @(posedge clk); #1;
      if (state != 3'd0) left = 1;
      if (left && (state == 3'd0 || state == 3'd5)) done = 1;
    end
    check("instr_completes", 32'(done), 32'd1);

    is_mem  = (op == 8'h03 || op == 8'h04);
    exp_cyc = base_cycles(op) + fw + (is_mem ? mw : 0);
    exp_ret = exp_ret + 16'd1;
    if (!known(op)) exp_ill = 1'b1;

    check("cycles", 32'(cyc), 32'(exp_cyc));
    check("reg_write_cnt", 32'(n_rw), (op == 8'h01 || op == 8'h02 || op == 8'h03) ? 32'd1 : 32'd0);
    check("pc_inc_cnt", 32'(n_inc),
          (op == 8'hFF) ? 32'd0 : (op == 8'h05) ? 32'(!zf) : 32'd1);
    check("pc_load_cnt", 32'(n_ld), (op == 8'h05 && zf) ? 32'd1 : 32'd0);
    check("pc_both_high", 32'(n_both), 32'd0);
    check("mem_we_cnt", 32'(n_we), (op == 8'h04) ? 32'(mw + 1) : 32'd0);
    check("data_req_cnt", 32'(n_dreq), is_mem ? 32'(mw + 1) : 32'd0);
    check("fetch_req_cnt", 32'(n_freq), 32'(fw + 1));
    check("ir_load_cnt", 32'(n_ir), 32'd1);
    check("alu_op_add", 32'(n_aluop), 32'd0);
    if (op == 8'h01 || op == 8'h02) begin
      check("alu_src", 32'(last_alu_src), 32'(op == 8'h02));
      check("reg_src_alu", 32'(last_reg_src), 32'd0);
    end
    if (op == 8'h03) check("reg_src_mem", 32'(last_reg_src), 32'd1);
    check("retired", 32'(retired), 32'(exp_ret));
    check("illegal", 32'(illegal), 32'(exp_ill));
    check("halted", 32'(halted), 32'(op == 8'hFF));
  endtask

  initial begin
    int c, tot;
    bit found;
    logic [7:0] op;

    rst_n = 1'b0; run = 1'b1; opcode = 8'h00; zero_flag = 1'b0; mem_ready = 1'b1;
    exp_ret = 16'd0; exp_ill = 1'b0;

    // reset state, strobes low even with run=1
    @(negedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_load", 32'(ir_load), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // released with run=0: no fetch, state holds
    @(negedge clk); rst_n = 1'b1; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("idle_no_req", 32'(mem_req), 32'd0);
      check("idle_state", 32'(state), 32'd0);
    end

    // ADD then ADDI: 6 cycles, retired +2
    run_instr(8'h01, 0, 0, 1'b0, 0, c); tot = c;
    run_instr(8'h02, 0, 0, 1'b0, 0, c); tot += c;
    check("add_addi_total", 32'(tot), 32'd6);

    // LOAD with 2 wait cycles in MEM
    run_instr(8'h03, 0, 2, 1'b0, 0, c);
    check("load_wait_total", 32'(c), 32'd6);

    // JMPZ taken then not taken
    run_instr(8'h05, 0, 0, 1'b1, 0, c);
    run_instr(8'h05, 0, 0, 1'b0, 0, c);

    // run dropped while STORE is in MEM
    run_instr(8'h04, 0, 1, 1'b0, 1, c);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); run = 1'b0; mem_ready = 1'($urandom_range(0, 1)); #1;
      check("run_low_no_req", 32'(mem_req), 32'd0);
      check("run_low_fetch", 32'(state), 32'd0);
    end

    // randomized instruction mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h02;
        3: op = 8'h03;
        4: op = 8'h04;
        5: op = 8'h05;
        default: op = 8'($urandom_range(6, 254));
      endcase
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 0, c);
    end

    // reset asserted mid-MEM of a LOAD stalled by mem_ready
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); run = 1'b1; opcode = 8'h03; #1;
      mem_ready = mem_req && !mem_addr_src; #1;
      if (state == 3'd3 && mem_req) found = 1;
    end
    check("reached_mem", 32'(found), 32'd1);
    rst_n = 1'b0; #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    check("midrst_illegal", 32'(illegal), 32'd0);
    exp_ret = 16'd0; exp_ill = 1'b0;
    @(negedge clk); rst_n = 1'b1; run = 1'b1; mem_ready = 1'b1; #1;
    check("restart_fetch_req", 32'(mem_req), 32'd1);
    check("restart_fetch_src", 32'(mem_addr_src), 32'd0);
    run = 1'b0; mem_ready = 1'b0;

    // unknown opcode then HALT
    run_instr(8'h7A, 0, 0, 1'b0, 0, c);
    check("illegal_set", 32'(illegal), 32'd1);
    run_instr(8'hFF, 1, 0, 1'b0, 0, c);
    check("halt_retired", 32'(retired), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); run = 1'b1; mem_ready = 1'($urandom_range(0, 1)); #1;
      check("halt_no_req", 32'(mem_req), 32'd0);
      check("halt_stays", 32'(halted), 32'd1);
      check("halt_no_pc", 32'(pc_inc | pc_load), 32'd0);
    end
    check("illegal_sticky", 32'(illegal), 32'd1);
    check("halt_retired_hold", 32'(retired), 32'(exp_ret));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
